// File: rtl/mlru_repl_if.sv
// mlru_repl_if -- bundles the access, invalidate, victim-query and flush
// signals of mlru_repl_array.
//   master : requester side (drives strobes, receives victim answer / busy)
//   slave  : replacement array side
// Handshake: every request (acc_valid_*, inv_valid, vic_req, flush_req) is a
// single-cycle strobe with no ready. A request is taken on the rising edge
// where it is high and flush_busy is low; while flush_busy is high all
// requests are dropped. vic_valid is a one-cycle pulse and vic_way is
// meaningful only while vic_valid is high.
interface mlru_repl_if #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);

    logic             acc_valid_0;
    logic [SET_W-1:0] acc_set_0;
    logic [WAY_W-1:0] acc_way_0;
    logic             acc_valid_1;
    logic [SET_W-1:0] acc_set_1;
    logic [WAY_W-1:0] acc_way_1;
    logic             inv_valid;
    logic [SET_W-1:0] inv_set;
    logic [WAY_W-1:0] inv_way;
    logic             vic_req;
    logic [SET_W-1:0] vic_set;
    logic             vic_valid;
    logic [WAY_W-1:0] vic_way;
    logic             flush_req;
    logic             flush_busy;

    modport master (
        output acc_valid_0, acc_set_0, acc_way_0,
        output acc_valid_1, acc_set_1, acc_way_1,
        output inv_valid, inv_set, inv_way,
        output vic_req, vic_set, flush_req,
        input  vic_valid, vic_way, flush_busy
    );

    modport slave (
        input  acc_valid_0, acc_set_0, acc_way_0,
        input  acc_valid_1, acc_set_1, acc_way_1,
        input  inv_valid, inv_set, inv_way,
        input  vic_req, vic_set, flush_req,
        output vic_valid, vic_way, flush_busy
    );
endinterface

// File: rtl/mlru_repl_array.sv
// mlru_repl_array -- MRU-bit (pseudo-LRU) replacement state for a
// NUM_SETS x NUM_WAYS cache, with two access ports, a single-way invalidate,
// a registered victim query and a sequential one-set-per-cycle flush.
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset, clears all state
//   bus       : mlru_repl_if slave modport (access/invalidate/victim/flush)
//   state_dbg : current FSM state (0 = IDLE, 1 = FLUSH)
module mlru_repl_array #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mlru_repl_if.slave   bus,
    output logic         state_dbg
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   cnt_q, cnt_d;

    logic [NUM_WAYS-1:0] mbit_q  [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] mbit_d  [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_d [NUM_SETS];

    logic                idle;
    logic [NUM_WAYS-1:0] oh_0, oh_1, oh_inv;
    logic                vic_valid_q;
    logic [WAY_W-1:0]    vic_way_q;

    assign idle   = (state_q == IDLE);
    assign oh_0   = NUM_WAYS'(1) << bus.acc_way_0;
    assign oh_1   = NUM_WAYS'(1) << bus.acc_way_1;
    assign oh_inv = NUM_WAYS'(1) << bus.inv_way;

    // Lowest invalid way, else lowest way with mbit clear, else way 0.
    function automatic logic [WAY_W-1:0] pick_victim(
        input logic [NUM_WAYS-1:0] v,
        input logic [NUM_WAYS-1:0] m
    );
        logic [WAY_W-1:0] res;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !v[w]) begin
                res   = WAY_W'(w);
                found = 1'b1;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !m[w]) begin
                res   = WAY_W'(w);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // FSM: next state and flush counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (cnt_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SET_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-set next mbit/valid. An invalidated way is removed from the hit
    // mask before the saturation test so it cannot trigger a reset of the
    // other ways' mbits, then cleared outright.
    always_comb begin
        logic [NUM_WAYS-1:0] hit, kill, merged;
        mbit_d  = mbit_q;
        valid_d = valid_q;
        for (int s = 0; s < NUM_SETS; s++) begin
            hit  = '0;
            kill = '0;
            if (idle && bus.acc_valid_0 && bus.acc_set_0 == SET_W'(s)) hit  = hit | oh_0;
            if (idle && bus.acc_valid_1 && bus.acc_set_1 == SET_W'(s)) hit  = hit | oh_1;
            if (idle && bus.inv_valid   && bus.inv_set   == SET_W'(s)) kill = oh_inv;
            hit    = hit & ~kill;
            merged = mbit_q[s] | hit;
            if (&hit) begin
                merged = '0;
            end else if (&merged) begin
                merged = hit;
            end
            mbit_d[s]  = merged & ~kill;
            valid_d[s] = (valid_q[s] | hit) & ~kill;
            if (!idle && cnt_q == SET_W'(s)) begin
                mbit_d[s]  = '0;
                valid_d[s] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                mbit_q[s]  <= '0;
                valid_q[s] <= '0;
            end
        end else begin
            mbit_q  <= mbit_d;
            valid_q <= valid_d;
        end
    end

    // Victim answer uses the pre-update state of the request cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vic_valid_q <= 1'b0;
            vic_way_q   <= '0;
        end else begin
            vic_valid_q <= idle && bus.vic_req;
            vic_way_q   <= (idle && bus.vic_req)
                         ? pick_victim(valid_q[bus.vic_set], mbit_q[bus.vic_set])
                         : '0;
        end
    end

    assign bus.vic_valid  = vic_valid_q;
    assign bus.vic_way    = vic_way_q;
    assign bus.flush_busy = !idle;
    assign state_dbg      = state_q;
endmodule

// File: doc/mlru_repl_array.md
MLRU_REPL_ARRAY -- requirements
Module: mlru_repl_array

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, way count per set, power of 2, >=2.
REQ-002 SHALL have parameter NUM_SETS, default 16, set count, power of 2, >=2.
REQ-003 SHALL derive WAY_W = log2(NUM_WAYS) and SET_W = log2(NUM_SETS).
REQ-004 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: acc_valid_0/acc_valid_1  input  1 each  access strobe, ports 0 and 1.
REQ-007 SHALL have ports: acc_set_0/acc_set_1  input  SET_W each  accessed set.
REQ-008 SHALL have ports: acc_way_0/acc_way_1  input  WAY_W each  accessed (hit or filled) way.
REQ-009 SHALL have ports: inv_valid  input  1, inv_set  input  SET_W, inv_way  input  WAY_W  single-way invalidate.
REQ-010 SHALL have ports: vic_req  input  1, vic_set  input  SET_W  victim query.
REQ-011 SHALL have ports: vic_valid  output  1, vic_way  output  WAY_W  registered victim answer.
REQ-012 SHALL have ports: flush_req  input  1  start full flush; flush_busy  output  1  flush in progress.

Function
REQ-013 SHALL hold per set an mbit vector (NUM_WAYS bits) and a valid vector (NUM_WAYS bits).
REQ-014 Access on a port SHALL set the valid bit and the mbit of (set, way) at the next rising edge.
REQ-015 Per-set hit mask = OR of one-hot ways of all valid ports addressing that set in the cycle.
REQ-016 Update: new = mbit | hitmask; if new is all ones, mbit SHALL become hitmask; if hitmask itself is all ones, mbit SHALL become 0.
REQ-017 Two ports on different sets SHALL update both sets independently in the same cycle.
REQ-018 Two ports on same set and same way SHALL act as one access.
REQ-019 Invalidate SHALL clear both the valid bit and mbit of (inv_set, inv_way), no saturation check.
REQ-020 Invalidate and access to the same (set, way) in one cycle: invalidate SHALL win; other ways still update.
REQ-021 Victim selection SHALL be: lowest-index way with valid=0; else lowest-index way with mbit=0; else way 0.
REQ-022 vic_valid SHALL pulse exactly one cycle after vic_req is sampled high; vic_way valid only while vic_valid=1.
REQ-023 Victim SHALL be computed from state before updates of the request cycle (read-before-write).
REQ-024 Victim query SHALL NOT modify state; back-to-back vic_req every cycle SHALL be supported.
REQ-025 FSM SHALL have states IDLE and FLUSH; flush_req in IDLE -> FLUSH, set counter = 0.
REQ-026 In FLUSH, one set per cycle SHALL have mbit and valid cleared, counter incrementing 0..NUM_SETS-1.
REQ-027 After clearing set NUM_SETS-1 the FSM SHALL return to IDLE; flush takes exactly NUM_SETS cycles.
REQ-028 flush_busy SHALL be 1 exactly while in FLUSH.
REQ-029 While flush_busy=1: accesses, invalidates, vic_req and flush_req SHALL be ignored; no vic_valid is produced.
REQ-030 flush_req same cycle as access/vic_req in IDLE: those SHALL complete normally; flush starts next cycle.

Reset
REQ-031 rst_n low SHALL immediately clear all mbit and valid vectors, FSM to IDLE, counter to 0.
REQ-032 During reset vic_valid=0, vic_way=0, flush_busy=0.
REQ-033 Reset asserted mid-flush SHALL abort the flush; state after release is fully cleared, IDLE.

Verification
REQ-034 After reset, vic_req set 5 -> next cycle vic_valid=1, vic_way=0.
REQ-035 Accesses set 2 to ways 0,1,2 (one per cycle), then vic_req set 2 -> vic_way=3.
REQ-036 Set 3 all valid, mbit=0111; port0 way3 + port1 way1 same cycle -> mbit=1010; vic_req set 3 -> vic_way=0.
REQ-037 Set 4 full valid, mbit=1011; inv_valid set 4 way 1 with port0 access set 4 way 1 same cycle -> valid=1101, mbit=1001; vic_req -> vic_way=1.
REQ-038 flush_req with sets populated -> flush_busy high 16 cycles; vic_req during flush ignored; after, vic_req set 15 -> vic_way=0.
REQ-039 rst_n pulsed low at flush cycle 7 -> flush_busy drops immediately, all sets cleared, vic_req any set -> vic_way=0.
